mul_err_monitor: RTL and testbench

Synthesizable on-chip error-statistics engine for the approximate multipliers (e.g. `wallace`). It generates pseudo-random 16-bit operand pairs and issues them to an external multiplier under test through a valid/ready handshake. It collects the returned products, compares each against the exact product, and accumulates error count, maximum error distance and summed error distance. The host derives NED from these results. It sits beside the multiplier in the CNN datapath so the approximation error of a configuration can be measured in silicon rather than only in simulation.

---
 rtl/mul_mon_pkg.sv | 22 ++
 rtl/mul_mon_fifo.sv | 70 +++++++
 rtl/mul_err_monitor.sv | 201 ++++++++++++++++++++
 tb/tb_mul_err_monitor.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_mon_pkg.sv
// rtl/mul_mon_pkg.sv - shared types and constants for the multiplier error monitor
`timescale 1ns/1ps
// Holds the monitor FSM state enum, the operand LFSR polynomial, the
// replacement seed used when a zero seed is supplied, and the LFSR step.
package mul_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } mon_state_e;

    // x^32 + x^22 + x^2 + x + 1 in right-shifting Galois form
    localparam logic [31:0] LFSR_POLY    = 32'h8020_0003;
    localparam logic [31:0] DEFAULT_SEED = 32'h0000_0001;

    function automatic logic [31:0] lfsr_next(input logic [31:0] cur);
        return {1'b0, cur[31:1]} ^ (cur[0] ? LFSR_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/mul_mon_fifo.sv
// rtl/mul_mon_fifo.sv - synchronous show-ahead FIFO holding exact products
`timescale 1ns/1ps
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   clr           synchronous flush
//   push, din     write strobe and data (caller guarantees not full)
//   pop, dout     read strobe and head-of-queue data (valid when not empty)
//   count         registered occupancy, 0..DEPTH
//   empty, full   occupancy flags derived from count
// DEPTH must be a power of two so the pointers wrap naturally.
module mul_mon_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    output logic [W-1:0]               dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_C);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // simultaneous push and pop leaves occupancy unchanged
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/mul_err_monitor.sv
// rtl/mul_err_monitor.sv - on-chip error statistics engine for approximate multipliers
`timescale 1ns/1ps
// Issues LFSR operand pairs to an external multiplier, keeps the exact
// products in a FIFO, and compares each returned product against them.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start, seed         run start pulse (IDLE/DONE only) and LFSR seed
//   op_valid/op_ready   operand handshake; op_a, op_b operands
//   res_valid, res_p    in-order returned approximate products
//   busy, done          RUN/DRAIN and DONE indication
//   proto_err           sticky: result arrived with nothing outstanding
//   err_cnt, max_ed     mismatch count and largest error distance
//   sum_ed, sum_ed_h2   summed error distance (first/second half)
// Optional feature macro ERR_MON_HALVES_EN: split the error-distance sum by
// result index into two accumulators; otherwise sum_ed_h2 is tied to zero.
// WIDTH must not exceed 16 since both operands are cut from one 32-bit LFSR.
module mul_err_monitor
    import mul_mon_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int N_SAMPLES  = 1000000,
    parameter int FIFO_DEPTH = 8,
    parameter int ACC_W      = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [31:0]          seed,
    output logic                 op_valid,
    input  logic                 op_ready,
    output logic [WIDTH-1:0]     op_a,
    output logic [WIDTH-1:0]     op_b,
    input  logic                 res_valid,
    input  logic [2*WIDTH-1:0]   res_p,
    output logic                 busy,
    output logic                 done,
    output logic                 proto_err,
    output logic [31:0]          err_cnt,
    output logic [2*WIDTH-1:0]   max_ed,
    output logic [ACC_W-1:0]     sum_ed,
    output logic [ACC_W-1:0]     sum_ed_h2
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0]   N_LIM   = 32'(N_SAMPLES);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    mon_state_e        state;
    logic [31:0]       lfsr;
    logic [31:0]       issue_cnt;

    logic [CW-1:0]     fifo_count;
    logic              fifo_empty;
    logic              fifo_full;
    logic [PW-1:0]     fifo_dout;
    logic [PW-1:0]     exact;

    logic              start_acc;
    logic              op_fire;
    logic              pop;

    logic signed [PW:0] diff;
    logic [PW-1:0]     ed_abs;

    logic              s1_valid;
    logic [PW-1:0]     s1_ed;
    logic              add_h1;

    assign start_acc = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign op_valid  = (state == ST_RUN) && (issue_cnt < N_LIM) && (fifo_count < DEPTH_C);
    assign op_fire   = op_valid && op_ready;
    assign pop       = res_valid && !fifo_empty;

    assign op_a  = lfsr[WIDTH-1:0];
    assign op_b  = lfsr[2*WIDTH-1:WIDTH];
    assign exact = PW'(op_a) * PW'(op_b);

    assign busy = (state == ST_RUN) || (state == ST_DRAIN);
    assign done = (state == ST_DONE);

    // one extra bit so an approximate product above the exact one stays signed
    assign diff   = $signed({1'b0, fifo_dout}) - $signed({1'b0, res_p});
    assign ed_abs = diff[PW] ? PW'(-diff) : diff[PW-1:0];

    mul_mon_fifo #(
        .W     (PW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (start_acc),
        .push  (op_fire && !fifo_full),
        .din   (exact),
        .pop   (pop),
        .dout  (fifo_dout),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

`ifdef ERR_MON_HALVES_EN
    localparam logic [31:0] HALF = 32'(N_SAMPLES / 2);

    logic [31:0] res_idx;
    logic        s1_h2;

    assign add_h1 = s1_valid && !s1_h2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_idx   <= '0;
            s1_h2     <= 1'b0;
            sum_ed_h2 <= '0;
        end else if (start_acc) begin
            res_idx   <= '0;
            s1_h2     <= 1'b0;
            sum_ed_h2 <= '0;
        end else begin
            if (pop) begin
                res_idx <= res_idx + 1'b1;
                s1_h2   <= (res_idx >= HALF);
            end
            if (s1_valid && s1_h2) begin
                sum_ed_h2 <= sum_ed_h2 + ACC_W'(s1_ed);
            end
        end
    end
`else
    assign add_h1    = s1_valid;
    assign sum_ed_h2 = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            lfsr      <= DEFAULT_SEED;
            issue_cnt <= '0;
            proto_err <= 1'b0;
            s1_valid  <= 1'b0;
            s1_ed     <= '0;
            err_cnt   <= '0;
            max_ed    <= '0;
            sum_ed    <= '0;
        end else begin
            // compare stage 1: error distance of the popped result
            s1_valid <= pop;
            if (pop) begin
                s1_ed <= ed_abs;
            end

            if (res_valid && fifo_empty) begin
                proto_err <= 1'b1;
            end

            // compare stage 2: fold into the statistics
            if (s1_valid) begin
                if (s1_ed != '0) begin
                    err_cnt <= err_cnt + 1'b1;
                end
                if (s1_ed > max_ed) begin
                    max_ed <= s1_ed;
                end
            end
            if (add_h1) begin
                sum_ed <= sum_ed + ACC_W'(s1_ed);
            end

            if (op_fire) begin
                lfsr      <= lfsr_next(lfsr);
                issue_cnt <= issue_cnt + 1'b1;
            end

            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        err_cnt   <= '0;
                        max_ed    <= '0;
                        sum_ed    <= '0;
                        proto_err <= 1'b0;
                        s1_valid  <= 1'b0;
                        lfsr      <= (seed == 32'h0) ? DEFAULT_SEED : seed;
                        issue_cnt <= '0;
                        state     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (issue_cnt == N_LIM) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (fifo_empty && !s1_valid) begin
                        state <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_err_monitor.sv
// tb/tb_mul_err_monitor.sv - self-checking bench for mul_err_monitor
`timescale 1ns/1ps
module tb_mul_err_monitor;
    localparam int NS    = 200;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] seed = 32'h0;
    logic        op_valid;
    logic        op_ready = 1'b1;
    logic [15:0] op_a, op_b;
    logic        res_valid = 1'b0;
    logic [31:0] res_p = 32'h0;
    logic        busy, done, proto_err;
    logic [31:0] err_cnt;
    logic [31:0] max_ed;
    logic [63:0] sum_ed, sum_ed_h2;

    mul_err_monitor #(
        .WIDTH(16), .N_SAMPLES(NS), .FIFO_DEPTH(DEPTH), .ACC_W(64)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .seed(seed),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .res_valid(res_valid), .res_p(res_p),
        .busy(busy), .done(done), .proto_err(proto_err),
        .err_cnt(err_cnt), .max_ed(max_ed), .sum_ed(sum_ed), .sum_ed_h2(sum_ed_h2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // multiplier-under-test behaviour, shared with the reference model
    int mode = 0;
    int lat = 1;
    int stall_from = -1;
    int stall_len = 0;
    int rnd_off [NS];

    function automatic int off_of(input int m, input int i);
        if (i < 0 || i >= NS) return 0;
        case (m)
            1: return 5;
            2: return (i % 2 == 1) ? -3 : 0;
            3: return rnd_off[i];
            default: return 0;
        endcase
    endfunction

    // responder: an external multiplier with fixed latency and op_ready stalls
    typedef struct { int due; logic [31:0] p; } pend_t;
    pend_t pq [$];
    pend_t pe;
    int run_gen = 0, seen_gen = 0, inj_gen = 0, inj_seen = 0;
    int n_hs = 0, n_res = 0, max_out = 0, ov_viol = 0, out_now, last_res_cyc = 0;
    logic [15:0] got_a [NS];
    logic [15:0] got_b [NS];

    always @(negedge clk) begin
        if (run_gen != seen_gen) begin
            seen_gen = run_gen;
            n_hs = 0; n_res = 0; max_out = 0; ov_viol = 0;
        end
        if (rst) begin
            pq.delete();
            res_valid = 1'b0;
            op_ready  = 1'b1;
        end else begin
            out_now = n_hs - n_res;
            if (out_now > max_out) max_out = out_now;
            if (op_valid && out_now >= DEPTH) ov_viol++;
            op_ready  = !(cyc >= stall_from && cyc < stall_from + stall_len);
            res_valid = 1'b0;
            if (pq.size() > 0 && pq[0].due == cyc) begin
                pe = pq.pop_front();
                res_valid = 1'b1;
                res_p = pe.p;
                n_res++;
                last_res_cyc = cyc;
            end else if (inj_gen != inj_seen) begin
                inj_seen  = inj_gen;
                res_valid = 1'b1;
                res_p     = $urandom;
            end
            if (op_valid && op_ready) begin
                if (n_hs < NS) begin
                    got_a[n_hs] = op_a;
                    got_b[n_hs] = op_b;
                end
                pe.due = cyc + lat;
                pe.p = 32'(longint'(op_a) * longint'(op_b) + longint'(off_of(mode, n_hs)));
                pq.push_back(pe);
                n_hs++;
            end
        end
    end

    // reference model: operand sequence and statistics from the seed
    logic [15:0] exp_a [NS];
    logic [15:0] exp_b [NS];
    longint e_err, e_max, e_s1, e_s2;

    task automatic model(input logic [31:0] s, input int m);
        logic [31:0] l;
        logic        out_bit;
        longint ex, r, d;
        int taps [4] = '{32, 22, 2, 1};
        l = (s == 32'h0) ? 32'h1 : s;
        e_err = 0; e_max = 0; e_s1 = 0; e_s2 = 0;
        for (int i = 0; i < NS; i++) begin
            exp_a[i] = l[15:0];
            exp_b[i] = l[31:16];
            ex = longint'(l[15:0]) * longint'(l[31:16]);
            r  = (ex + longint'(off_of(m, i))) & 64'h0000_0000_FFFF_FFFF;
            d  = ex - r;
            if (d < 0) d = -d;
            if (d != 0) e_err++;
            if (d > e_max) e_max = d;
`ifdef ERR_MON_HALVES_EN
            if (i < NS / 2) e_s1 += d; else e_s2 += d;
`else
            e_s1 += d;
`endif
            // divide by the polynomial: shift toward x^0, fold the dropped term back in
            out_bit = l[0];
            l = l >> 1;
            if (out_bit) foreach (taps[t]) l[taps[t]-1] = ~l[taps[t]-1];
        end
    endtask

    int done_cyc;

    task automatic launch(input logic [31:0] s, input int m, input int l, input int st_rel, input int st_len);
        mode = m; lat = l; stall_len = st_len;
        run_gen++;
        @(negedge clk);
        @(negedge clk);
        seed = s;
        start = 1'b1;
        stall_from = (st_len > 0) ? cyc + st_rel : -1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_and_check(input string tag, input logic [31:0] s, input int m,
                                 input int l, input int st_rel, input int st_len);
        int k;
        int mism;
        launch(s, m, l, st_rel, st_len);
        chk({tag, "_first_op_valid"}, op_valid, 1);
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_proto_clear"}, proto_err, 0);
        k = 0;
        while (!done && k < 5000) begin
            @(negedge clk);
            k++;
        end
        done_cyc = cyc;
        chk({tag, "_done"}, done, 1);
        model(s, m);
        mism = 0;
        for (int i = 0; i < NS; i++)
            if (got_a[i] !== exp_a[i] || got_b[i] !== exp_b[i]) mism++;
        chk({tag, "_operands"}, mism, 0);
        chk({tag, "_n_results"}, n_res, NS);
        chk({tag, "_err_cnt"}, err_cnt, e_err);
        chk({tag, "_max_ed"}, max_ed, e_max);
        chk({tag, "_sum_ed"}, sum_ed, e_s1);
        chk({tag, "_sum_ed_h2"}, sum_ed_h2, e_s2);
        chk({tag, "_proto_err"}, proto_err, 0);
        chk({tag, "_op_valid_at_full"}, ov_viol, 0);
    endtask

    initial begin
        int k;
        for (int i = 0; i < NS; i++)
            rnd_off[i] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 2000)) - 1000;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_op_valid", op_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_proto_err", proto_err, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_sum_ed", sum_ed, 0);
        chk("rst_lfsr_a", op_a, 1);
        chk("rst_lfsr_b", op_b, 0);
        rst = 1'b0;
        @(negedge clk);

        // result with nothing outstanding while idle
        inj_gen++;
        repeat (4) @(negedge clk);
        chk("idle_proto_err", proto_err, 1);
        chk("idle_err_cnt", err_cnt, 0);
        chk("idle_max_ed", max_ed, 0);
        chk("idle_sum_ed", sum_ed, 0);
        chk("idle_busy", busy, 0);

        // ideal multiplier, zero seed replaced by 1, latency 1
        run_and_check("ideal", 32'h0, 0, 1, 0, 0);
        chk("ideal_done_latency", done_cyc - last_res_cyc, 3);

        run_and_check("plus5", 32'hACE1_2345, 1, 1, 0, 0);
        run_and_check("odd_minus3", 32'h1357_9BDF, 2, 1, 0, 0);
        run_and_check("random_off", 32'hDEAD_BEEF, 3, 3, 0, 0);

        // latency 10 with a 20-cycle op_ready stall; same seed as above
        run_and_check("stall", 32'hDEAD_BEEF, 3, 10, 40, 20);
        chk("stall_max_outstanding", max_out, DEPTH);

        // reset mid-run aborts everything
        launch(32'h0BAD_F00D, 3, 2, 0, 0);
        k = 0;
        while (n_res < 50 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk("midrun_reached_50", (n_res >= 50), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrun_op_valid", op_valid, 0);
        chk("midrun_busy", busy, 0);
        chk("midrun_done", done, 0);
        chk("midrun_proto_err", proto_err, 0);
        chk("midrun_err_cnt", err_cnt, 0);
        chk("midrun_max_ed", max_ed, 0);
        chk("midrun_sum_ed", sum_ed, 0);
        chk("midrun_sum_ed_h2", sum_ed_h2, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_and_check("restart", 32'h0BAD_F00D, 3, 2, 0, 0);

        // a result arriving in DONE is also a protocol error; start clears it
        inj_gen++;
        repeat (3) @(negedge clk);
        chk("done_proto_err", proto_err, 1);
        run_and_check("after_proto", 32'h0000_0077, 1, 1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
